// File: rtl/serial_match_arb_if.sv
// serial_match_arb_if: requester/result handshake bundle for serial_match_arb.
// master drives requests and res_ready; slave is the arbiter side.
interface serial_match_arb_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic [1:0]        req_valid;
  logic [WORD_W-1:0] req_data0;
  logic [WORD_W-1:0] req_data1;
  logic [1:0]        req_ready;
  logic              res_valid;
  logic              res_ready;
  logic              res_id;
  logic [CNT_W-1:0]  res_count;
  logic              busy;

  modport master (
    output req_valid, req_data0, req_data1, res_ready,
    input  req_ready, res_valid, res_id, res_count, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1, res_ready,
    output req_ready, res_valid, res_id, res_count, busy
  );
endinterface

// File: rtl/serial_match_arb.sv
// serial_match_arb: round-robin 2-requester arbiter feeding a serial "1101" counter.
// Optional macro MATCH_CARRY_EN keeps detector state per requester across words.
module serial_match_arb #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input logic               clk,
  input logic               rst,
  serial_match_arb_if.slave bus
);

  localparam int BW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  typedef enum logic [2:0] {
    D_IDLE,
    D_S1,
    D_S2,
    D_S3,
    D_SUCC
  } det_t;

  state_t            state;
  state_t            state_nxt;
  det_t              det;
  det_t              det_nxt;
  det_t              det_start;
  logic              ptr;
  logic              gnt;
  logic              gnt_id;
  logic [WORD_W-1:0] word;
  logic [BW-1:0]     bit_cnt;
  logic              last_bit;
  logic              bit_in;
  logic              hit;
  logic              id;
  logic [CNT_W-1:0]  count;

  assign bit_in   = word[WORD_W-1];
  assign last_bit = (bit_cnt == BW'(WORD_W - 1));
  assign hit      = (det_nxt == D_SUCC);

  // Pick the requester: pointer owner on contention, else the lone one.
  always_comb begin
    gnt_id = 1'b0;
    unique case (bus.req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr;
      default: gnt_id = 1'b0;
    endcase
  end

  // Job sequencing: grant in IDLE, serialize, hold result until taken.
  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          gnt       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_nxt = REPORT;
      end
      REPORT: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Overlapping "1101" Moore detector transition.
  always_comb begin
    det_nxt = D_IDLE;
    unique case (det)
      D_IDLE:  det_nxt = bit_in ? D_S1   : D_IDLE;
      D_S1:    det_nxt = bit_in ? D_S2   : D_IDLE;
      D_S2:    det_nxt = bit_in ? D_S2   : D_S3;
      D_S3:    det_nxt = bit_in ? D_SUCC : D_IDLE;
      D_SUCC:  det_nxt = bit_in ? D_S2   : D_IDLE;
      default: det_nxt = D_IDLE;
    endcase
  end

`ifdef MATCH_CARRY_EN
  det_t carry [2];

  assign det_start = carry[gnt_id];

  // Save the final detector state of each requester's finished job.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry[0] <= D_IDLE;
      carry[1] <= D_IDLE;
    end else if (state == SHIFT && last_bit) begin
      carry[id] <= det_nxt;
    end
  end
`else
  assign det_start = D_IDLE;
`endif

  // Capture on grant, then shift MSB first and count saturating matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 1'b0;
      id      <= 1'b0;
      word    <= '0;
      bit_cnt <= '0;
      count   <= '0;
      det     <= D_IDLE;
    end else if (gnt) begin
      ptr     <= ~gnt_id;
      id      <= gnt_id;
      word    <= gnt_id ? bus.req_data1 : bus.req_data0;
      bit_cnt <= '0;
      count   <= '0;
      det     <= det_start;
    end else if (state == SHIFT) begin
      word    <= {word[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + BW'(1);
      det     <= det_nxt;
      if (hit && count != '1) count <= count + CNT_W'(1);
    end
  end

  assign bus.req_ready = (gnt && !rst) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.res_valid = (state == REPORT);
  assign bus.res_id    = id;
  assign bus.res_count = count;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_match_arb.sv
// tb_serial_match_arb: scoreboard bench for serial_match_arb.
// Reference counts come from a sliding-window model, carry-aware via MATCH_CARRY_EN.
module tb_serial_match_arb;
  localparam int W = 8;
  localparam int C = 4;

  typedef struct packed {
    logic         id;
    logic [C-1:0] count;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb [$];
  logic ptr_m;
  logic [2:0] hist_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_match_arb_if #(.WORD_W(W), .CNT_W(C)) sif ();

  serial_match_arb #(.WORD_W(W), .CNT_W(C)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  function automatic int count_1101(input logic [2:0] prev, input logic [W-1:0] w);
    logic [W+2:0] s;
    int n;
    s = {prev, w};
    n = 0;
    for (int k = W + 2; k >= 3; k--)
      if (s[k -: 4] == 4'b1101) n++;
    return n;
  endfunction

  function automatic logic model_grant(input logic [1:0] v);
    return (v == 2'b11) ? ptr_m : v[1];
  endfunction

  task automatic expect_job(input logic g, input logic [W-1:0] w);
    res_t e;
    logic [2:0] prev;
    int n;
`ifdef MATCH_CARRY_EN
    prev = hist_m[g];
    hist_m[g] = w[2:0];
`else
    prev = 3'b000;
`endif
    n = count_1101(prev, w);
    if (n > (1 << C) - 1) n = (1 << C) - 1;
    e.id = g;
    e.count = C'(n);
    sb.push_back(e);
    ptr_m = ~g;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick;
    rst = 1'b0;
    ptr_m = 1'b0;
    hist_m[0] = 3'b000;
    hist_m[1] = 3'b000;
    sb.delete();
  endtask

  task automatic wait_grant(output logic [1:0] g, output int t, output bit to);
    int i;
    to = 1'b1;
    g = 2'b00;
    t = 0;
    i = 0;
    while (to && i < 40) begin
      @(negedge clk);
      if (sif.req_ready !== 2'b00) begin
        g = sif.req_ready;
        t = cyc;
        to = 1'b0;
      end
      i++;
    end
  endtask

  task automatic wait_res(output res_t r, output int t, output bit to);
    int i;
    to = 1'b1;
    r = '0;
    t = 0;
    i = 0;
    while (to && i < 40) begin
      @(negedge clk);
      if (sif.res_valid === 1'b1) begin
        r.id = sif.res_id;
        r.count = sif.res_count;
        t = cyc;
        to = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_reset;
    logic [1:0] g;
    int tg;
    bit to;
    bit seen;
    sif.req_valid = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sif.req_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_ready_gate: got %b want 00", sif.req_ready);
    end
    sif.req_valid = 2'b00;
    do_reset(2);
    @(negedge clk);
    n_cmp++;
    if ({sif.res_valid, sif.busy, sif.req_ready, sif.res_id, sif.res_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b b=%b r=%b id=%b c=%0d want all 0",
               sif.res_valid, sif.busy, sif.req_ready, sif.res_id, sif.res_count);
    end
    tick;
    sif.req_data0 = 8'b11010000;
    sif.req_valid = 2'b01;
    wait_grant(g, tg, to);
    n_cmp++;
    if (to || g !== 2'b01) begin
      n_bad++;
      $display("FAIL abort_grant: got %b timeout=%0d want 01", g, to);
    end
    tick;
    sif.req_valid = 2'b00;
    repeat (3) tick;
    @(negedge clk);
    n_cmp++;
    if (sif.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL shift_busy: got %b want 1", sif.busy);
    end
    tick;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sif.res_valid, sif.busy, sif.req_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_state: got v=%b b=%b r=%b want 0 0 00",
               sif.res_valid, sif.busy, sif.req_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sif.res_valid === 1'b1 || sif.req_ready !== 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_result: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_single_match;
    logic [W-1:0] words [2];
    logic [1:0] g;
    int tg, tr;
    bit to;
    res_t r, e;
    words[0] = 8'b11010000;
    words[1] = 8'b11011011;
    do_reset(2);
    sif.res_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      sif.req_data0 = words[j];
      sif.req_valid = 2'b01;
      expect_job(model_grant(2'b01), words[j]);
      wait_grant(g, tg, to);
      n_cmp++;
      if (to || g !== 2'b01) begin
        n_bad++;
        $display("FAIL single_grant[%0d]: got %b want 01", j, g);
      end
      tick;
      sif.req_valid = 2'b00;
      wait_res(r, tr, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || tr - tg != W + 1) begin
        n_bad++;
        $display("FAIL single_latency[%0d]: got %0d want %0d", j, tr - tg, W + 1);
      end
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL single_result[%0d]: got id=%b c=%0d want id=%b c=%0d",
                 j, r.id, r.count, e.id, e.count);
      end
      tick;
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] g, eg;
    logic gm;
    int tg, tr;
    bit to;
    res_t r, e;
    do_reset(2);
    sif.res_ready = 1'b1;
    sif.req_data0 = 8'b11010000;
    sif.req_data1 = 8'b11011011;
    sif.req_valid = 2'b11;
    for (int j = 0; j < 3; j++) begin
      gm = model_grant(2'b11);
      eg = gm ? 2'b10 : 2'b01;
      expect_job(gm, gm ? sif.req_data1 : sif.req_data0);
      wait_grant(g, tg, to);
      n_cmp++;
      if (to || g !== eg) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", j, g, eg);
      end
      wait_res(r, tr, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || tr - tg != W + 1) begin
        n_bad++;
        $display("FAIL rr_latency[%0d]: got %0d want %0d", j, tr - tg, W + 1);
      end
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL rr_result[%0d]: got id=%b c=%0d want id=%b c=%0d",
                 j, r.id, r.count, e.id, e.count);
      end
    end
    tick;
    sif.req_valid = 2'b00;
  endtask

  task automatic test_backpressure;
    logic [1:0] g;
    int tg, tr, i, spur;
    bit to, unstable;
    res_t r, e;
    do_reset(2);
    sif.res_ready = 1'b0;
    sif.req_data1 = 8'b11011010;
    sif.req_valid = 2'b10;
    expect_job(model_grant(2'b10), sif.req_data1);
    wait_grant(g, tg, to);
    n_cmp++;
    if (to || g !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_grant: got %b want 10", g);
    end
    tick;
    sif.req_valid = 2'b11;
    spur = 0;
    to = 1'b1;
    i = 0;
    while (to && i < 40) begin
      @(negedge clk);
      if (sif.req_ready !== 2'b00) spur++;
      if (sif.res_valid === 1'b1) begin
        r.id = sif.res_id;
        r.count = sif.res_count;
        tr = cyc;
        to = 1'b0;
      end
      i++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (to || tr - tg != W + 1) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want %0d", tr - tg, W + 1);
    end
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL bp_result: got id=%b c=%0d want id=%b c=%0d",
               r.id, r.count, e.id, e.count);
    end
    unstable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (sif.req_ready !== 2'b00) spur++;
      if (sif.res_valid !== 1'b1 || sif.res_id !== e.id || sif.res_count !== e.count)
        unstable = 1'b1;
    end
    n_cmp++;
    if (spur != 0) begin
      n_bad++;
      $display("FAIL bp_no_grant: got %0d grant pulses want 0", spur);
    end
    n_cmp++;
    if (unstable !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_hold: got unstable=%b want 0", unstable);
    end
    tick;
    sif.res_ready = 1'b1;
    sif.req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (sif.res_valid !== 1'b1 || sif.res_count !== e.count) begin
      n_bad++;
      $display("FAIL bp_handshake: got v=%b c=%0d want 1 %0d",
               sif.res_valid, sif.res_count, e.count);
    end
    @(negedge clk);
    n_cmp++;
    if (sif.busy !== 1'b0 || sif.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_idle: got b=%b v=%b want 0 0", sif.busy, sif.res_valid);
    end
  endtask

  task automatic test_carry;
    logic [W-1:0] words [2];
    logic [1:0] g;
    int tg, tr;
    bit to;
    res_t r, e;
    logic [C-1:0] want2;
`ifdef MATCH_CARRY_EN
    want2 = C'(1);
`else
    want2 = C'(0);
`endif
    words[0] = 8'b00000110;
    words[1] = 8'b10000000;
    do_reset(2);
    sif.res_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      sif.req_data0 = words[j];
      sif.req_valid = 2'b01;
      expect_job(model_grant(2'b01), words[j]);
      wait_grant(g, tg, to);
      n_cmp++;
      if (to || g !== 2'b01) begin
        n_bad++;
        $display("FAIL carry_grant[%0d]: got %b want 01", j, g);
      end
      tick;
      sif.req_valid = 2'b00;
      wait_res(r, tr, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || r !== e) begin
        n_bad++;
        $display("FAIL carry_result[%0d]: got id=%b c=%0d want id=%b c=%0d",
                 j, r.id, r.count, e.id, e.count);
      end
      if (j == 1) begin
        n_cmp++;
        if (r.count !== want2) begin
          n_bad++;
          $display("FAIL carry_span: got %0d want %0d", r.count, want2);
        end
      end
      tick;
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.req_valid = 2'b00;
    sif.req_data0 = '0;
    sif.req_data1 = '0;
    sif.res_ready = 1'b0;
    test_reset;
    test_single_match;
    test_round_robin;
    test_backpressure;
    test_carry;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
